// File: rtl/risc16_mc_control_if.sv
// ---------------------------------------------------------------------------
// risc16_mc_control_if
//   Shared instruction/data memory handshake between the RiSC-16 multi-cycle
//   controller (master) and the memory port (slave).
//   mem_req      request, held until mem_ack
//   mem_we       1 = write, meaningful only with mem_req
//   mem_addr_sel address mux: 0 = PC, 1 = ALUOut
//   mem_ack      request completes this cycle (may coincide with mem_req rise)
//
//   Also provides the ALU funct codes used by the controller.
// ---------------------------------------------------------------------------
`ifndef ALU_FUNCT_LEN
`define ALU_FUNCT_LEN 2
`define ALU_ADD   2'd0
`define ALU_NAND  2'd1
`define ALU_PASSA 2'd2
`define ALU_SUB   2'd3
`endif

interface risc16_mc_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ack;

   modport master (output mem_req, mem_we, mem_addr_sel, input mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ack);
endinterface

// File: rtl/risc16_mc_control.sv
// ---------------------------------------------------------------------------
// risc16_mc_control
//   Multi-cycle control FSM for the RiSC-16 core. Sequences the datapath
//   through FETCH/DECODE/EXEC/MEM/WB, halts on JALR with nonzero imm7, and
//   counts retired instructions.
//
//   clk, reset    clock; synchronous active-high reset
//   opcode        IR[15:13]
//   imm7_nz       IR[6:0] != 0 (selects HALT for JALR)
//   alu_zero      ALU result == 0, resolves BEQ
//   mem           memory handshake (master side)
//   ir_we, mdr_we, pc_we, aluout_we, reg_we   datapath write strobes
//   pc_src        0 = PC+1, 1 = PC+simm7, 2 = regB
//   rf_rd2_sel    0 = rC, 1 = rA
//   alu_src1_sel  0 = regB, 1 = imm10<<6
//   alu_src2_sel  0 = rf port2, 1 = simm7
//   alu_funct     ALU operation
//   wb_sel        0 = ALUOut, 1 = MDR, 2 = PC
//   halted        HALT state reached
//   retired       completed-instruction count (wraps)
// ---------------------------------------------------------------------------
module risc16_mc_control #(
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2:0]                opcode,
   input  logic                      imm7_nz,
   input  logic                      alu_zero,
   risc16_mc_control_if.master       mem,
   output logic                      ir_we,
   output logic                      mdr_we,
   output logic                      pc_we,
   output logic [1:0]                pc_src,
   output logic                      rf_rd2_sel,
   output logic                      alu_src1_sel,
   output logic                      alu_src2_sel,
   output logic [`ALU_FUNCT_LEN-1:0] alu_funct,
   output logic                      aluout_we,
   output logic                      reg_we,
   output logic [1:0]                wb_sel,
   output logic                      halted,
   output logic [CNT_W-1:0]          retired
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t state, state_nx;
   logic   retire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (retire) retired <= retired + CNT_W'(1);
      end
   end

   // Outputs stay at their defaults for the whole reset cycle, so a pending
   // memory request is dropped and no partial write can escape.
   always_comb begin
      state_nx         = state;
      mem.mem_req      = 1'b0;
      mem.mem_we       = 1'b0;
      mem.mem_addr_sel = 1'b0;
      ir_we            = 1'b0;
      mdr_we           = 1'b0;
      pc_we            = 1'b0;
      pc_src           = 2'd0;
      rf_rd2_sel       = 1'b0;
      alu_src1_sel     = 1'b0;
      alu_src2_sel     = 1'b0;
      alu_funct        = `ALU_ADD;
      aluout_we        = 1'b0;
      reg_we           = 1'b0;
      wb_sel           = 2'd0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               mem.mem_req = 1'b1;
               if (mem.mem_ack) begin
                  ir_we    = 1'b1;
                  pc_we    = 1'b1;
                  state_nx = S_DECODE;
               end
            end
            S_DECODE: begin
               rf_rd2_sel = (opcode == OP_SW) || (opcode == OP_BEQ);
               state_nx   = (opcode == OP_JALR && imm7_nz) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               rf_rd2_sel = (opcode == OP_SW) || (opcode == OP_BEQ);
               aluout_we  = (opcode != OP_BEQ) && (opcode != OP_JALR);
               state_nx   = S_WB;
               case (opcode)
                  OP_ADD:  ;
                  OP_ADDI: alu_src2_sel = 1'b1;
                  OP_NAND: alu_funct = `ALU_NAND;
                  OP_LUI: begin
                     alu_funct    = `ALU_PASSA;
                     alu_src1_sel = 1'b1;
                  end
                  OP_SW, OP_LW: begin
                     alu_src2_sel = 1'b1;
                     state_nx     = S_MEM;
                  end
                  OP_BEQ: begin
                     alu_funct = `ALU_SUB;
                     if (alu_zero) begin
                        pc_we  = 1'b1;
                        pc_src = 2'd1;
                     end
                     state_nx = S_FETCH;
                  end
                  default: begin
                     // JALR: link write sees the PC before this cycle's update
                     reg_we   = 1'b1;
                     wb_sel   = 2'd2;
                     pc_we    = 1'b1;
                     pc_src   = 2'd2;
                     state_nx = S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               mem.mem_req      = 1'b1;
               mem.mem_addr_sel = 1'b1;
               mem.mem_we       = (opcode == OP_SW);
               if (mem.mem_ack) begin
                  if (opcode == OP_SW) state_nx = S_FETCH;
                  else begin
                     mdr_we   = 1'b1;
                     state_nx = S_WB;
                  end
               end
            end
            S_WB: begin
               reg_we   = 1'b1;
               wb_sel   = (opcode == OP_LW) ? 2'd1 : 2'd0;
               state_nx = S_FETCH;
            end
            default: ;  // HALT: no strobes, wait for reset
         endcase
      end
   end

   assign retire = !reset && (state_nx == S_FETCH) &&
                   (state == S_EXEC || state == S_MEM || state == S_WB);
   assign halted = (state == S_HALT);

endmodule

// File: tb/tb_risc16_mc_control.sv
// ---------------------------------------------------------------------------
// tb_risc16_mc_control
//   Drives instruction sequences with random memory wait states and checks
//   per-instruction strobe totals, EXEC-cycle ALU controls, write-back and
//   PC source selection, retired count (narrow counter so wrap is reached),
//   reset behaviour and HALT.
// ---------------------------------------------------------------------------
`ifndef ALU_FUNCT_LEN
`define ALU_FUNCT_LEN 2
`define ALU_ADD   2'd0
`define ALU_NAND  2'd1
`define ALU_PASSA 2'd2
`define ALU_SUB   2'd3
`endif

module tb_risc16_mc_control;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic reset;
   logic [2:0] opcode;
   logic imm7_nz, alu_zero;
   logic ir_we, mdr_we, pc_we, rf_rd2_sel, alu_src1_sel, alu_src2_sel;
   logic aluout_we, reg_we, halted;
   logic [1:0] pc_src, wb_sel;
   logic [`ALU_FUNCT_LEN-1:0] alu_funct;
   logic [CNT_W-1:0] retired;

   risc16_mc_control_if mif ();

   risc16_mc_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .imm7_nz(imm7_nz),
      .alu_zero(alu_zero), .mem(mif.master), .ir_we(ir_we), .mdr_we(mdr_we),
      .pc_we(pc_we), .pc_src(pc_src), .rf_rd2_sel(rf_rd2_sel),
      .alu_src1_sel(alu_src1_sel), .alu_src2_sel(alu_src2_sel),
      .alu_funct(alu_funct), .aluout_we(aluout_we), .reg_we(reg_we),
      .wb_sel(wb_sel), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int model_ret = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int strobes();
      return int'({mif.mem_req, mif.mem_we, ir_we, mdr_we, pc_we, aluout_we, reg_we});
   endfunction

   function automatic int exp_funct(input logic [2:0] op);
      case (op)
         3'd2:    return int'(`ALU_NAND);
         3'd3:    return int'(`ALU_PASSA);
         3'd6:    return int'(`ALU_SUB);
         default: return int'(`ALU_ADD);
      endcase
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // One instruction starting in FETCH: wf fetch wait cycles, wm memory wait
   // cycles. Expected behaviour comes from the per-opcode rules only.
   task automatic run_instr(input logic [2:0] op, input logic nz, input logic z,
                            input int wf, input int wm);
      bit has_mem, has_wb, br;
      int n, mem_lo, mem_hi;
      int c_ir, c_pc, c_reg, c_mdr, c_alu, c_req, c_req_a, c_we;
      int f_ex, s1_ex, s2_ex, rd2_ex, wbs, pcs;
      logic ack;
      string t;
      has_mem = (op == 3'd4) || (op == 3'd5);
      has_wb  = (op <= 3'd3) || (op == 3'd5);
      br      = (op == 3'd6 && z) || (op == 3'd7);
      n       = wf + 3 + (has_mem ? wm + 1 : 0) + (has_wb ? 1 : 0);
      mem_lo  = wf + 3;
      mem_hi  = wf + 3 + wm;
      c_ir = 0; c_pc = 0; c_reg = 0; c_mdr = 0; c_alu = 0;
      c_req = 0; c_req_a = 0; c_we = 0;
      f_ex = -1; s1_ex = -1; s2_ex = -1; rd2_ex = -1; wbs = -1; pcs = -1;
      opcode = op; imm7_nz = nz; alu_zero = z;
      for (int i = 0; i < n; i++) begin
         if (i <= wf) ack = (i == wf);
         else if (has_mem && i >= mem_lo && i <= mem_hi) ack = (i == mem_hi);
         else ack = 1'($urandom % 2);
         mif.mem_ack = ack;
         @(negedge clk);
         c_ir += int'(ir_we); c_pc += int'(pc_we); c_reg += int'(reg_we);
         c_mdr += int'(mdr_we); c_alu += int'(aluout_we);
         c_req += int'(mif.mem_req);
         c_req_a += int'(mif.mem_req && mif.mem_addr_sel);
         c_we += int'(mif.mem_req && mif.mem_we);
         if (i == wf + 2) begin
            f_ex = int'(alu_funct); s1_ex = int'(alu_src1_sel);
            s2_ex = int'(alu_src2_sel); rd2_ex = int'(rf_rd2_sel);
         end
         if (reg_we) wbs = int'(wb_sel);
         if (pc_we && !ir_we) pcs = int'(pc_src);
         next_cyc();
      end
      model_ret = (model_ret + 1) % (1 << CNT_W);
      t = $sformatf("op%0d z%0d wf%0d wm%0d", op, z, wf, wm);
      chk({t, " ir_we"}, c_ir, 1);
      chk({t, " pc_we"}, c_pc, br ? 2 : 1);
      chk({t, " reg_we"}, c_reg, (has_wb || op == 3'd7) ? 1 : 0);
      chk({t, " mdr_we"}, c_mdr, (op == 3'd5) ? 1 : 0);
      chk({t, " aluout_we"}, c_alu, (op == 3'd6 || op == 3'd7) ? 0 : 1);
      chk({t, " mem_req"}, c_req, wf + 1 + (has_mem ? wm + 1 : 0));
      chk({t, " mem_addr1"}, c_req_a, has_mem ? wm + 1 : 0);
      chk({t, " mem_we"}, c_we, (op == 3'd4) ? wm + 1 : 0);
      chk({t, " funct"}, f_ex, exp_funct(op));
      chk({t, " src1"}, s1_ex, (op == 3'd3) ? 1 : 0);
      chk({t, " src2"}, s2_ex, (op == 3'd1 || op == 3'd4 || op == 3'd5) ? 1 : 0);
      chk({t, " rd2"}, rd2_ex, (op == 3'd4 || op == 3'd6) ? 1 : 0);
      if (has_wb || op == 3'd7)
         chk({t, " wb_sel"}, wbs, (op == 3'd5) ? 1 : (op == 3'd7) ? 2 : 0);
      if (br) chk({t, " pc_src"}, pcs, (op == 3'd6) ? 1 : 2);
      chk({t, " retired"}, int'(retired), model_ret);
      chk({t, " halted"}, int'(halted), 0);
      chk({t, " fetch_next"}, int'({mif.mem_req, mif.mem_addr_sel}), 2);
   endtask

   initial begin
      logic [2:0] op;
      logic nz;
      reset = 1'b1; opcode = 3'd5; imm7_nz = 1'b0; alu_zero = 1'b0;
      mif.mem_ack = 1'b1;
      @(negedge clk);
      chk("reset strobes", strobes(), 0);
      next_cyc();
      reset = 1'b0;
      mif.mem_ack = 1'b0;
      @(negedge clk);
      chk("reset retired", int'(retired), 0);
      chk("reset halted", int'(halted), 0);
      chk("reset fetch", int'({mif.mem_req, mif.mem_addr_sel}), 2);
      next_cyc();

      // directed instructions
      run_instr(3'd0, 1'b0, 1'b0, 0, 0);   // ADD, zero wait
      run_instr(3'd6, 1'b0, 1'b1, 0, 0);   // BEQ taken
      run_instr(3'd6, 1'b0, 1'b0, 0, 0);   // BEQ not taken
      run_instr(3'd5, 1'b0, 1'b0, 0, 3);   // LW with 3 wait cycles
      run_instr(3'd4, 1'b0, 1'b0, 2, 1);   // SW
      run_instr(3'd7, 1'b0, 1'b0, 0, 0);   // JALR (not halt)

      // random stream; long enough for the narrow counter to wrap
      for (int k = 0; k < 300; k++) begin
         op = 3'($urandom % 8);
         nz = (op == 3'd7) ? 1'b0 : 1'($urandom % 2);
         run_instr(op, nz, 1'($urandom % 2), int'($urandom % 3), int'($urandom % 3));
      end

      // reset while waiting in MEM
      opcode = 3'd5; imm7_nz = 1'b0;
      mif.mem_ack = 1'b1; next_cyc();        // FETCH ack
      mif.mem_ack = 1'b0; next_cyc();        // DECODE
      next_cyc();                            // EXEC
      @(negedge clk);
      chk("midmem req", int'({mif.mem_req, mif.mem_addr_sel}), 3);
      next_cyc();
      reset = 1'b1; mif.mem_ack = 1'b1;
      @(negedge clk);
      chk("midmem reset strobes", strobes(), 0);
      next_cyc();
      reset = 1'b0; mif.mem_ack = 1'b0;
      @(negedge clk);
      chk("midmem fetch", int'({mif.mem_req, mif.mem_addr_sel, mif.mem_we}), 4);
      chk("midmem retired", int'(retired), 0);
      model_ret = 0;
      next_cyc();

      for (int k = 0; k < 20; k++)
         run_instr(3'($urandom % 7), 1'b0, 1'($urandom % 2), int'($urandom % 2), int'($urandom % 2));

      // HALT
      opcode = 3'd7; imm7_nz = 1'b1; mif.mem_ack = 1'b1;
      @(negedge clk);
      chk("halt fetch ir_we", int'(ir_we), 1);
      next_cyc();
      mif.mem_ack = 1'($urandom % 2);
      @(negedge clk);
      chk("halt decode strobes", strobes(), 0);
      next_cyc();
      for (int k = 0; k < 20; k++) begin
         mif.mem_ack = 1'(k % 2);
         @(negedge clk);
         chk($sformatf("halt %0d halted", k), int'(halted), 1);
         chk($sformatf("halt %0d strobes", k), strobes(), 0);
         next_cyc();
      end
      chk("halt retired", int'(retired), model_ret);
      reset = 1'b1;
      @(negedge clk);
      chk("halt reset strobes", strobes(), 0);
      next_cyc();
      reset = 1'b0; mif.mem_ack = 1'b0;
      @(negedge clk);
      chk("post-halt halted", int'(halted), 0);
      chk("post-halt retired", int'(retired), 0);
      chk("post-halt fetch", int'({mif.mem_req, mif.mem_addr_sel}), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
